// File: rtl/pmu_bitstream_seq_pkg.sv
// Shared constants and state encoding for the PMU serial-load sequencer.
package pmu_seq_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned CRC_W      = 8;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned GAP_CYCLES = 2;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  // One counter walks payload bits, then CRC bits, then the gap.
  localparam int unsigned BIT_CNT_W = $clog2(WORD_W + CRC_W);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CRC,
    STALL,
    GAP,
    ERR
  } state_t;

endpackage

// File: rtl/pmu_bitstream_seq_if.sv
// Frame-word valid/ready channel from the JTAG-side buffer into the sequencer.
interface pmu_bitstream_seq_if;
  import pmu_seq_pkg::*;

  logic [WORD_W-1:0] word_i;
  logic              word_valid_i;
  logic              word_ready_o;

  modport master (output word_i, output word_valid_i, input word_ready_o);
  modport slave  (input word_i, input word_valid_i, output word_ready_o);

endinterface

// File: rtl/pmu_bitstream_seq_crc8.sv
// Bit-serial CRC-8 (MSB-first register, init 0); clear has priority over enable.
module crc8_serial
  import pmu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/pmu_bitstream_seq.sv
// Serializes header + N data frames LSB-first onto the PMU load port,
// optionally appending a CRC-8 per frame; owns the PMU en/data/checksum pins.
module pmu_bitstream_seq
  import pmu_seq_pkg::*;
(
  input  logic               tck_i,
  input  logic               rst_i,
  input  logic               checksum_en_i,
  pmu_bitstream_seq_if.slave word_if,
  output logic               pmu_en_o,
  output logic               pmu_data_o,
  output logic               pmu_checksum_en_o,
  input  logic               pmu_err_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   frames_left_o
);

  localparam logic [BIT_CNT_W-1:0] LAST_PAY = BIT_CNT_W'(WORD_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_CRC = BIT_CNT_W'(WORD_W + CRC_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_GAP = BIT_CNT_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    sreg_q, sreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mode_q, mode_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic                 en, shift_bit, ready, load_data, frame_last;
  logic                 crc_clr, crc_en, crc_bit;
  logic [CRC_W-1:0]     crc;

  crc8_serial u_crc (
    .clk    (tck_i),
    .rst_n  (rst_i),
    .clear  (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_ff @(posedge tck_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    count_d    = count_q;
    mode_d     = mode_q;
    err_d      = err_q;
    done_d     = 1'b0;
    en         = 1'b0;
    shift_bit  = 1'b0;
    ready      = 1'b0;
    load_data  = 1'b0;
    frame_last = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_bit    = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (word_if.word_valid_i) begin
          state_d   = SHIFT;
          sreg_d    = word_if.word_i;
          bit_cnt_d = '0;
          count_d   = word_if.word_i[CNT_W-1:0];
          mode_d    = checksum_en_i;
          err_d     = 1'b0;
          crc_clr   = 1'b1;
        end
      end
      SHIFT: begin
        en        = 1'b1;
        shift_bit = sreg_q[0];
        crc_en    = 1'b1;
        crc_bit   = sreg_q[0];
        sreg_d    = {1'b0, sreg_q[WORD_W-1:1]};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == LAST_PAY) begin
          if (mode_q) state_d = CRC;
          else        frame_last = 1'b1;
        end
      end
      CRC: begin
        // Feeding the register its own MSB zeroes the feedback, so it shifts out MSB-first.
        en         = 1'b1;
        shift_bit  = crc[CRC_W-1];
        crc_en     = 1'b1;
        crc_bit    = crc[CRC_W-1];
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        frame_last = (bit_cnt_q == LAST_CRC);
      end
      STALL: begin
        ready     = 1'b1;
        load_data = word_if.word_valid_i;
      end
      GAP: begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == LAST_GAP) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready window on the last bit of a frame is withheld when the PMU flags an error.
    if (frame_last) begin
      if (count_q != '0) begin
        ready     = !pmu_err_i;
        load_data = word_if.word_valid_i && ready;
        if (!load_data) state_d = STALL;
      end else begin
        state_d   = GAP;
        bit_cnt_d = '0;
      end
    end

    if (load_data) begin
      state_d   = SHIFT;
      sreg_d    = word_if.word_i;
      bit_cnt_d = '0;
      count_d   = count_q - CNT_W'(1);
      crc_clr   = 1'b1;
    end

    if (en && pmu_err_i) begin
      state_d = ERR;
      err_d   = 1'b1;
    end
  end

  assign word_if.word_ready_o = ready && rst_i;
  assign pmu_en_o             = en;
  assign pmu_data_o           = shift_bit;
  assign pmu_checksum_en_o    = mode_q;
  assign busy_o               = (state_q != IDLE) && (state_q != ERR);
  assign done_o               = done_q;
  assign err_o                = err_q;
  assign frames_left_o        = count_q;

endmodule

// File: doc/pmu_bitstream_seq.md
Name: pmu_bitstream_seq

Overview:
- Sequences the PMU's serial load port: accepts 64-bit frame words over a valid/ready interface and serializes them LSB-first onto the PMU `data_i`, framed by `en_i`.
- A burst is one header frame followed by N data frames, where N = header[15:0].
- With checksum mode on, each frame is followed by a CRC-8 computed by this block, giving 72 bits per frame.
- Sits between the JTAG-side word buffer and the pmu instance; it owns `en_i`, `data_i` and `checksum_en_i` of the PMU.

Parameters:
- WORD_W, 64, frame payload width in bits.
- CRC_W, 8, checksum width; fixed at 8 in this revision.
- CNT_W, 16, width of the frame-count field in header[CNT_W-1:0].
- CRC_POLY, 8'h07, CRC-8 polynomial x^8+x^2+x+1.

Ports:
- tck_i  in  1  clock (PMU TCK domain).
- rst_i  in  1  asynchronous active-low reset.
- checksum_en_i  in  1  CRC mode request; sampled only when a header word is accepted.
- word_i  in  WORD_W  frame word (header or data).
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  word accepted when valid&ready at a tck_i edge.
- pmu_en_o  out  1  to pmu en_i.
- pmu_data_o  out  1  to pmu data_i.
- pmu_checksum_en_o  out  1  to pmu checksum_en_i; latched copy of the mode for the burst.
- pmu_err_i  in  1  PMU integrity-failure flag.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle pulse when a burst completes normally.
- err_o  out  1  sticky abort flag.
- frames_left_o  out  CNT_W  data frames still to send.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All outputs 0 and state IDLE.
  - A reset mid-frame drops pmu_en_o immediately; the partial frame is abandoned and no done_o is raised.
- States: IDLE, SHIFT, CRC, STALL, GAP, ERR.
- IDLE:
  - word_ready_o=1.
  - On header accept: latch mode into pmu_checksum_en_o, load count=word_i[CNT_W-1:0], load the shift register, clear err_o, then go to SHIFT.
- SHIFT:
  - Asserts pmu_en_o=1 and pmu_data_o=sreg[0] for WORD_W cycles, bit 0 first.
  - The first bit appears in the cycle after acceptance.
  - The CRC is updated serially with each bit driven: init 8'h00, fb = crc[7]^bit, crc = {crc[6:0],0} ^ (fb ? CRC_POLY : 0).
  - After the last payload bit: go to CRC if mode=1; otherwise go to frame end.
- CRC:
  - Drives crc[7] first (MSB-first) for CRC_W cycles with pmu_en_o=1.
  - The CRC register is re-inited at the start of every frame.
- Frame end (last bit cycle of payload or CRC):
  - If more data frames remain, word_ready_o=1 in that same cycle.
  - If a word is accepted, the next frame starts in the following cycle with no gap and pmu_en_o stays high.
  - If no word is valid, go to STALL.
  - If no data frames remain (count==0 after the header, or after the last data frame), go to GAP.
- frames_left_o decrements on each data-word acceptance.
- STALL: pmu_en_o=0, pmu_data_o=0, word_ready_o=1; on accept go to SHIFT.
- GAP:
  - pmu_en_o=0 for 2 cycles.
  - Then done_o pulses for 1 cycle, busy_o drops, and the state returns to IDLE.
- busy_o=1 in every state except IDLE and ERR.
- pmu_err_i:
  - Sampled while pmu_en_o=1.
  - On a high sample: go to ERR in the next cycle, with pmu_en_o=0, err_o=1 and word_ready_o=0 for one cycle.
  - Then go to IDLE; err_o stays set until the next header is accepted.
- Words offered while not in a ready window are not accepted.
- checksum_en_i changes mid-burst are ignored.

Decomposition:
- Package pmu_seq_pkg holds:
  - the state enum;
  - constants WORD_W, CRC_W, CRC_POLY and CNT_W;
  - the GAP_CYCLES constant, value 2.
- Sub-module crc8_serial (clear, enable, bit in, crc out) is instantiated once. It is reused by the bench as its reference model.

Test Plan:
- Reset values: hold rst_i low with word_valid_i=1 -> all outputs 0 and no accept. Release -> word_ready_o=1 and busy_o=0.
- No-CRC burst:
  - Stimulus: header=64'h3 with three data words 64'h10BC3800_03802007, all back-to-back.
  - Required: pmu_en_o high for exactly 256 contiguous cycles, and the bit stream equals the words LSB-first.
  - Then 2 idle cycles followed by done_o=1 for 1 cycle; frames_left_o steps 3,2,1,0.
- CRC burst:
  - Stimulus: checksum_en_i=1, header=64'h3, three all-zero data words.
  - Required: 72-bit frames, 288 en cycles, and the data-frame CRC bits are 8'h00.
  - The header CRC must equal the crc8_serial model for 64'h3; pmu_checksum_en_o=1 throughout the burst.
- Stall:
  - Stimulus: word_valid_i low for 5 cycles after the header.
  - Required: pmu_en_o=0 for those 5 cycles, then the data frame resumes intact with no bit lost.
- Error and zero-count:
  - Stimulus: pmu_err_i pulsed at bit 10 of data frame 1.
  - Required: pmu_en_o low the next cycle, err_o=1, no done_o. A following header=64'h0 clears err_o and sends the header only, then done_o.
- Reset mid-frame: assert rst_i low at bit 30 -> pmu_en_o=0 immediately, frames_left_o=0, and a new burst afterwards runs correctly.
